// File: rtl/fg_prog_pkg.sv
// Shared types and constants for the floating-gate programming sequencer.
package fg_prog_pkg;

  localparam int ROW_BITS = 6;
  localparam int COL_BITS = 6;
  localparam int CNT_W    = 8;
  localparam int PW_W     = 16;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISOLATE = 3'd1,
    S_SELECT  = 3'd2,
    S_PULSE   = 3'd3,
    S_GAP     = 3'd4,
    S_RELEASE = 3'd5,
    S_RESTORE = 3'd6,
    S_RESP    = 3'd7
  } state_e;

  typedef enum logic [1:0] {
    ST_OK        = 2'd0,
    ST_ERR_RANGE = 2'd1,
    ST_ABORTED   = 2'd2
  } status_e;

  localparam logic MODE_INJECT = 1'b0;
  localparam logic MODE_TUNNEL = 1'b1;

endpackage

// File: rtl/fg_prog_sequencer_if.sv
// Command/response handshake plus the programming-mux control outputs.
interface fg_prog_sequencer_if;
  import fg_prog_pkg::*;

  logic                cmd_valid;
  logic                cmd_ready;
  logic [ROW_BITS-1:0] cmd_row;
  logic [COL_BITS-1:0] cmd_col;
  logic                cmd_mode;
  logic [CNT_W-1:0]    cmd_npulse;
  logic [PW_W-1:0]     cmd_pwidth;
  logic                abort;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [1:0]          rsp_status;
  logic [COL_BITS-1:0] dec_h_addr;
  logic [ROW_BITS-1:0] dec_v_addr;
  logic                dec_en;
  logic                drain_sel_en;
  logic                prog_sw_en;
  logic                vinj_pulse;
  logic                tun_pulse;
  logic                busy;

  modport master (
    output cmd_valid, cmd_row, cmd_col, cmd_mode, cmd_npulse, cmd_pwidth, abort, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_status, dec_h_addr, dec_v_addr, dec_en, drain_sel_en,
           prog_sw_en, vinj_pulse, tun_pulse, busy
  );

  modport slave (
    input  cmd_valid, cmd_row, cmd_col, cmd_mode, cmd_npulse, cmd_pwidth, abort, rsp_ready,
    output cmd_ready, rsp_valid, rsp_status, dec_h_addr, dec_v_addr, dec_en, drain_sel_en,
           prog_sw_en, vinj_pulse, tun_pulse, busy
  );

endinterface

// File: rtl/fg_prog_timer.sv
// Loadable down-counter shared by the settle, pulse-width and gap phases.
// Loading value N gives N+1 cycles before expired_o is seen.
module fg_prog_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] value_i,
  output logic         expired_o
);

  logic [W-1:0] count_q, count_d;

  // Load has priority; otherwise count down and park at zero.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = value_i;
    end else if (count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign expired_o = (count_q == '0);

endmodule

// File: rtl/fg_prog_sequencer.sv
// Programming-mux sequencer: one command in, isolate/select/pulse/release/restore, one status out.
//
//  state   | meaning
//  IDLE    | waiting for a command, cmd_ready high
//  ISOLATE | FG_MEM switches to program position, settle
//  SELECT  | decoder address applied, dec_en and drain_sel_en high, settle
//  PULSE   | selected injection/tunnel pulse high for pulse width
//  GAP     | pulse low between consecutive pulses
//  RELEASE | decoders and drain select off, address held, settle
//  RESTORE | switches back, address cleared, settle
//  RESP    | status offered until rsp_ready
module fg_prog_sequencer #(
  parameter int NUM_ROWS   = 9,
  parameter int NUM_COLS   = 18,
  parameter int SETTLE_CYC = 16,
  parameter int GAP_CYC    = 8
) (
  input  logic clk,
  input  logic rst_n,
  fg_prog_sequencer_if.slave bus
);
  import fg_prog_pkg::*;

  localparam int S_M1 = SETTLE_CYC - 1;
  localparam int G_M1 = GAP_CYC - 1;
  localparam logic [PW_W-1:0]   S_LOAD  = S_M1[PW_W-1:0];
  localparam logic [PW_W-1:0]   G_LOAD  = G_M1[PW_W-1:0];
  localparam logic [ROW_BITS:0] ROW_LIM = NUM_ROWS[ROW_BITS:0];
  localparam logic [COL_BITS:0] COL_LIM = NUM_COLS[COL_BITS:0];

  state_e              state_q, state_d;
  status_e             status_q, status_d;
  logic [ROW_BITS-1:0] row_q, row_d;
  logic [COL_BITS-1:0] col_q, col_d;
  logic                mode_q, mode_d;
  logic [CNT_W-1:0]    npulse_q, npulse_d;
  logic [CNT_W-1:0]    left_q, left_d;
  logic [PW_W-1:0]     pw_load_q, pw_load_d;

  logic                cmd_ready_q, cmd_ready_d;
  logic                busy_q, busy_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                prog_sw_q, prog_sw_d;
  logic                sel_q, sel_d;
  logic                vinj_q, vinj_d;
  logic                tun_q, tun_d;
  logic [COL_BITS-1:0] h_addr_q, h_addr_d;
  logic [ROW_BITS-1:0] v_addr_q, v_addr_d;

  logic                tmr_load;
  logic [PW_W-1:0]     tmr_value;
  logic                tmr_expired;

  fg_prog_timer #(.W(PW_W)) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (tmr_load),
    .value_i   (tmr_value),
    .expired_o (tmr_expired)
  );

  // Next state, phase timer loads and registered-output values derived from the next state.
  always_comb begin
    state_d   = state_q;
    status_d  = status_q;
    row_d     = row_q;
    col_d     = col_q;
    mode_d    = mode_q;
    npulse_d  = npulse_q;
    left_d    = left_q;
    pw_load_d = pw_load_q;
    h_addr_d  = h_addr_q;
    v_addr_d  = v_addr_q;
    tmr_load  = 1'b0;
    tmr_value = S_LOAD;

    unique case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid && cmd_ready_q) begin
          row_d     = bus.cmd_row;
          col_d     = bus.cmd_col;
          mode_d    = bus.cmd_mode;
          npulse_d  = bus.cmd_npulse;
          pw_load_d = (bus.cmd_pwidth == '0) ? '0 : bus.cmd_pwidth - 1'b1;
          if (({1'b0, bus.cmd_row} >= ROW_LIM) || ({1'b0, bus.cmd_col} >= COL_LIM)) begin
            status_d = ST_ERR_RANGE;
            state_d  = S_RESP;
          end else begin
            status_d = ST_OK;
            state_d  = S_ISOLATE;
            tmr_load = 1'b1;
          end
        end
      end
      S_ISOLATE, S_SELECT, S_PULSE, S_GAP: begin
        if (bus.abort) begin
          // Early termination still walks the safe release/restore path.
          status_d = ST_ABORTED;
          state_d  = S_RELEASE;
          tmr_load = 1'b1;
        end else if (tmr_expired) begin
          tmr_load = 1'b1;
          if (state_q == S_ISOLATE) begin
            state_d  = S_SELECT;
            h_addr_d = col_q;
            v_addr_d = row_q;
          end else if (state_q == S_SELECT) begin
            if (npulse_q == '0) begin
              state_d = S_RELEASE;
            end else begin
              state_d   = S_PULSE;
              tmr_value = pw_load_q;
              left_d    = npulse_q - 1'b1;
            end
          end else if (state_q == S_PULSE) begin
            if (left_q == '0) begin
              state_d = S_RELEASE;
            end else begin
              state_d   = S_GAP;
              tmr_value = G_LOAD;
            end
          end else begin
            state_d   = S_PULSE;
            tmr_value = pw_load_q;
            left_d    = left_q - 1'b1;
          end
        end
      end
      S_RELEASE: begin
        if (tmr_expired) begin
          state_d  = S_RESTORE;
          tmr_load = 1'b1;
          h_addr_d = '0;
          v_addr_d = '0;
        end
      end
      S_RESTORE: begin
        if (tmr_expired) state_d = S_RESP;
      end
      S_RESP: begin
        if (bus.rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    cmd_ready_d = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
    rsp_valid_d = (state_d == S_RESP);
    prog_sw_d   = state_d inside {S_ISOLATE, S_SELECT, S_PULSE, S_GAP, S_RELEASE};
    sel_d       = state_d inside {S_SELECT, S_PULSE, S_GAP};
    vinj_d      = (state_d == S_PULSE) && (mode_d == MODE_INJECT);
    tun_d       = (state_d == S_PULSE) && (mode_d == MODE_TUNNEL);
  end

  // State, latched command and registered outputs; reset forces every enable off.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      status_q    <= ST_OK;
      row_q       <= '0;
      col_q       <= '0;
      mode_q      <= 1'b0;
      npulse_q    <= '0;
      left_q      <= '0;
      pw_load_q   <= '0;
      cmd_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      prog_sw_q   <= 1'b0;
      sel_q       <= 1'b0;
      vinj_q      <= 1'b0;
      tun_q       <= 1'b0;
      h_addr_q    <= '0;
      v_addr_q    <= '0;
    end else begin
      state_q     <= state_d;
      status_q    <= status_d;
      row_q       <= row_d;
      col_q       <= col_d;
      mode_q      <= mode_d;
      npulse_q    <= npulse_d;
      left_q      <= left_d;
      pw_load_q   <= pw_load_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      rsp_valid_q <= rsp_valid_d;
      prog_sw_q   <= prog_sw_d;
      sel_q       <= sel_d;
      vinj_q      <= vinj_d;
      tun_q       <= tun_d;
      h_addr_q    <= h_addr_d;
      v_addr_q    <= v_addr_d;
    end
  end

  assign bus.cmd_ready    = cmd_ready_q;
  assign bus.busy         = busy_q;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_status   = status_q;
  assign bus.prog_sw_en   = prog_sw_q;
  assign bus.dec_en       = sel_q;
  assign bus.drain_sel_en = sel_q;
  assign bus.vinj_pulse   = vinj_q;
  assign bus.tun_pulse    = tun_q;
  assign bus.dec_h_addr   = h_addr_q;
  assign bus.dec_v_addr   = v_addr_q;

endmodule

// File: tb/tb_fg_prog_sequencer.sv
// Directed plus random bench for fg_prog_sequencer with a cycle-level reference model.
module tb_fg_prog_sequencer;

  localparam int S = 4;
  localparam int G = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_assert = 0;
  int   n_fail = 0;

  fg_prog_sequencer_if bus ();

  fg_prog_sequencer #(
    .NUM_ROWS  (9),
    .NUM_COLS  (18),
    .SETTLE_CYC(S),
    .GAP_CYC   (G)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int cyc, input logic [31:0] obs, input logic [31:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp_v);
    end
  endtask

  task automatic chk_all_off(input string tag, input int cyc);
    chk({tag, "_prog_sw"}, cyc, bus.prog_sw_en, 0);
    chk({tag, "_dec_en"}, cyc, bus.dec_en, 0);
    chk({tag, "_drain"}, cyc, bus.drain_sel_en, 0);
    chk({tag, "_vinj"}, cyc, bus.vinj_pulse, 0);
    chk({tag, "_tun"}, cyc, bus.tun_pulse, 0);
    chk({tag, "_haddr"}, cyc, bus.dec_h_addr, 0);
    chk({tag, "_vaddr"}, cyc, bus.dec_v_addr, 0);
    chk({tag, "_rsp_valid"}, cyc, bus.rsp_valid, 0);
  endtask

  // One command end to end. abort_at = cycle (1 = first cycle after accept) during which
  // abort is held high; 0 means no abort. hold = extra cycles rsp_ready stays low in RESP.
  task automatic run_cmd(input int row, input int col, input int mode, input int n, input int w,
                         input int abort_at, input int hold);
    int  weff, pe_n, pe, rsp, exp_st, t;
    bit  err, ab;
    weff   = (w == 0) ? 1 : w;
    err    = (row >= 9) || (col >= 18);
    pe_n   = (n == 0) ? 2*S : 2*S + n*weff + (n-1)*G;
    ab     = !err && abort_at >= 1 && abort_at <= pe_n;
    pe     = ab ? abort_at : pe_n;
    rsp    = err ? 1 : pe + 2*S + 1;
    exp_st = err ? 1 : (ab ? 2 : 0);

    t = 0;
    while (bus.cmd_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("cmd_ready_idle", 0, bus.cmd_ready, 1);
    bus.cmd_row    = 6'(row);
    bus.cmd_col    = 6'(col);
    bus.cmd_mode   = mode[0];
    bus.cmd_npulse = 8'(n);
    bus.cmd_pwidth = 16'(w);
    bus.abort      = 1'b0;
    bus.rsp_ready  = 1'b0;
    bus.cmd_valid  = 1'b1;

    for (int c = 1; c <= rsp; c++) begin
      bit e_psw, e_sel, e_pls, e_addr;
      int k;
      @(negedge clk);
      bus.cmd_valid  = 1'b0;
      bus.cmd_row    = 6'($urandom);
      bus.cmd_col    = 6'($urandom);
      bus.cmd_mode   = 1'($urandom);
      bus.cmd_npulse = 8'($urandom);
      bus.cmd_pwidth = 16'($urandom);
      k      = c - 2*S - 1;
      e_psw  = !err && (c <= pe + S);
      e_sel  = !err && (c > S) && (c <= pe);
      e_pls  = !err && (c > 2*S) && (c <= pe) && ((k % (weff+G)) < weff) && ((k / (weff+G)) < n);
      e_addr = !err && (c > S) && (pe > S) && (c <= pe + S);
      chk("prog_sw_en", c, bus.prog_sw_en, e_psw);
      chk("dec_en", c, bus.dec_en, e_sel);
      chk("drain_sel_en", c, bus.drain_sel_en, e_sel);
      chk("vinj_pulse", c, bus.vinj_pulse, e_pls && (mode == 0));
      chk("tun_pulse", c, bus.tun_pulse, e_pls && (mode == 1));
      chk("dec_h_addr", c, bus.dec_h_addr, e_addr ? col : 0);
      chk("dec_v_addr", c, bus.dec_v_addr, e_addr ? row : 0);
      chk("busy", c, bus.busy, 1);
      chk("cmd_ready_busy", c, bus.cmd_ready, 0);
      chk("rsp_valid", c, bus.rsp_valid, (c == rsp));
      if (c == rsp) chk("rsp_status", c, bus.rsp_status, exp_st);
      bus.abort     = (c == abort_at);
      bus.rsp_ready = (c < rsp) ? 1'($urandom) : (hold == 0);
    end

    for (int h = 1; h <= hold; h++) begin
      @(negedge clk);
      chk("rsp_valid_hold", rsp + h, bus.rsp_valid, 1);
      chk("rsp_status_hold", rsp + h, bus.rsp_status, exp_st);
      chk("cmd_ready_hold", rsp + h, bus.cmd_ready, 0);
      bus.abort     = 1'($urandom);
      bus.cmd_valid = 1'b1;
      bus.rsp_ready = (h == hold);
    end

    @(negedge clk);
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b0;
    bus.abort     = 1'b0;
    chk("rsp_valid_after", rsp + hold + 1, bus.rsp_valid, 0);
    chk("cmd_ready_after", rsp + hold + 1, bus.cmd_ready, 1);
    chk("busy_after", rsp + hold + 1, bus.busy, 0);
  endtask

  initial begin
    bus.cmd_valid  = 1'b0;
    bus.cmd_row    = '0;
    bus.cmd_col    = '0;
    bus.cmd_mode   = 1'b0;
    bus.cmd_npulse = '0;
    bus.cmd_pwidth = '0;
    bus.abort      = 1'b0;
    bus.rsp_ready  = 1'b0;

    repeat (3) @(negedge clk);
    chk_all_off("reset", 0);
    chk("reset_cmd_ready", 0, bus.cmd_ready, 0);
    chk("reset_busy", 0, bus.busy, 0);
    chk("reset_status", 0, bus.rsp_status, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("cmd_ready_after_reset", 0, bus.cmd_ready, 1);

    run_cmd(3, 5, 0, 2, 3, 0, 0);
    run_cmd(2, 7, 1, 0, 5, 0, 0);
    run_cmd(9, 0, 0, 3, 2, 0, 1);
    run_cmd(0, 18, 1, 3, 2, 0, 0);
    run_cmd(8, 17, 1, 1, 2, 0, 0);
    run_cmd(4, 4, 0, 5, 10, 13, 0);
    run_cmd(1, 2, 1, 3, 2, 2, 0);
    run_cmd(6, 9, 0, 3, 2, 14, 0);
    run_cmd(5, 3, 0, 2, 0, 0, 10);
    run_cmd(7, 11, 1, 2, 3, 26, 2);

    // Reset while a pulse is high: everything must drop on the next edge, no response later.
    run_cmd(9, 9, 0, 0, 0, 0, 0);
    bus.cmd_row    = 6'd1;
    bus.cmd_col    = 6'd1;
    bus.cmd_mode   = 1'b0;
    bus.cmd_npulse = 8'd5;
    bus.cmd_pwidth = 16'd10;
    bus.cmd_valid  = 1'b1;
    repeat (11) begin
      @(negedge clk);
      bus.cmd_valid = 1'b0;
    end
    chk("vinj_before_reset", 11, bus.vinj_pulse, 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk_all_off("midreset", 12);
    chk("midreset_busy", 12, bus.busy, 0);
    chk("midreset_cmd_ready", 12, bus.cmd_ready, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("cmd_ready_post_reset", 13, bus.cmd_ready, 1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk_all_off("post_reset", 14 + i);
      chk("post_reset_busy", 14 + i, bus.busy, 0);
    end

    for (int i = 0; i < 25; i++) begin
      int ab_at;
      ab_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 40)) : 0;
      run_cmd(int'($urandom_range(0, 10)), int'($urandom_range(0, 20)), int'($urandom_range(0, 1)),
              int'($urandom_range(0, 4)), int'($urandom_range(0, 5)), ab_at, int'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
